// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [WIDTH_DEF-1:0] DIV0_LO = '1;

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    FIX,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction at operand latch
// and sign restoration of results.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed shift-add multiply / restoring divide feeding HI/LO.
// Optional early multiply termination: define MULT_DIV_EARLY_OUT_EN.
//
// state    | meaning
// IDLE     | waiting for mult_start / div_start
// MULT_RUN | one shift-add step per cycle on operand magnitudes
// DIV_RUN  | one restoring-division step per cycle on magnitudes
// FIX      | apply result signs, register hi/lo
// DONE     | one-cycle done pulse, results valid
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_done,
  output logic             div_done,
  output logic             div_by_zero,
  output logic             busy
);

  state_t             state, state_nxt;
  op_t                op_q;
  logic               sign_a_q, sign_b_q, dz_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;    // mult: {partial product, multiplier}; div: low half is dividend/quotient
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   mcand_q;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic               start_any, start_div0;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.value(a_in), .negate(a_in[WIDTH-1]), .result(mag_a));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.value(b_in), .negate(b_in[WIDTH-1]), .result(mag_b));
  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value(acc_q), .negate(sign_a_q ^ sign_b_q), .result(prod_fix));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .value(acc_q[WIDTH-1:0]), .negate(sign_a_q ^ sign_b_q), .result(quo_fix));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.value(rem_q), .negate(sign_a_q), .result(rem_fix));

  assign start_any  = mult_start | div_start;
  assign start_div0 = ~mult_start & div_start & (b_in == '0);

  // Multiply step: conditional add into the upper half, then shift right by one.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign mul_step = {add_sum, acc_q[WIDTH-1:1]};

  // Magnitudes never exceed 2^(WIDTH-1), so the remainder fits WIDTH-1 bits and
  // the shifted value's top bit is clear; the trial's top bit is then a true sign.
  logic [WIDTH:0] div_shift, div_trial;
  logic           div_ge;
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcand_q};
  assign div_ge    = ~div_trial[WIDTH];

  logic               early_out;
  logic [2*WIDTH-1:0] acc_skip;
`ifdef MULT_DIV_EARLY_OUT_EN
  // Remaining multiplier bits sit in acc_q[cnt_q-1:0]; once zero, the rest is pure shifting.
  logic [WIDTH-1:0] rem_mask;
  assign rem_mask  = ~({WIDTH{1'b1}} << cnt_q);
  assign early_out = (state == MULT_RUN) && ((acc_q[WIDTH-1:0] & rem_mask) == '0);
  assign acc_skip  = acc_q >> cnt_q;
`else
  assign early_out = 1'b0;
  assign acc_skip  = mul_step;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mult_start)      state_nxt = MULT_RUN;
        else if (start_div0) state_nxt = DONE;
        else if (div_start)  state_nxt = DIV_RUN;
      end
      MULT_RUN: if (cnt_q == CNT_W'(1) || early_out) state_nxt = FIX;
      DIV_RUN:  if (cnt_q == CNT_W'(1)) state_nxt = FIX;
      FIX:      state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_any) begin
            op_q     <= mult_start ? OP_MULT : OP_DIV;
            sign_a_q <= a_in[WIDTH-1];
            sign_b_q <= b_in[WIDTH-1];
            dz_q     <= start_div0;
            cnt_q    <= CNT_W'(WIDTH);
            mcand_q  <= mult_start ? mag_a : mag_b;
            acc_q    <= {{WIDTH{1'b0}}, (mult_start ? mag_b : mag_a)};
            rem_q    <= '0;
            if (start_div0) begin
              hi_q <= a_in;
              lo_q <= DIV0_LO;
            end
          end
        end
        MULT_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          acc_q <= early_out ? acc_skip : mul_step;
        end
        DIV_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (div_ge) begin
            rem_q             <= div_trial[WIDTH-1:0];
            acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q             <= div_shift[WIDTH-1:0];
            acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (op_q == OP_MULT) begin
            {hi_q, lo_q} <= prod_fix;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign mult_done   = (state == DONE) && (op_q == OP_MULT);
  assign div_done    = (state == DONE) && (op_q == OP_DIV);
  assign div_by_zero = div_done && dz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model plus directed vectors.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mult_start = 1'b0;
  logic         div_start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [W-1:0] hi_out, lo_out;
  logic         mult_done, div_done, div_by_zero, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
    .mult_done(mult_done), .div_done(div_done), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one outstanding operation, results computed with plain arithmetic.
  bit         m_active = 0;
  bit         m_mult = 0;
  bit         m_dz = 0;
  int         m_start = 0;
  int         m_done_at = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int mult_latency(input logic [W-1:0] b);
`ifdef MULT_DIV_EARLY_OUT_EN
    longint m;
    int len;
    int run;
    m = $signed(b);
    if (m < 0) m = -m;
    len = 0;
    while (m != 0) begin
      len++;
      m = m >> 1;
    end
    run = (len + 1 > W) ? W : len + 1;
    return run + 2;
`else
    return W + 2;
`endif
  endfunction

  function automatic bit model_idle();
    return !(m_active && cyc >= m_start + 1 && cyc <= m_done_at);
  endfunction

  task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] prod;
    int lat;
    mult_start = m;
    div_start = d;
    a_in = a;
    b_in = b;
    if ((m || d) && model_idle()) begin
      if (m_active && cyc >= m_done_at) begin
        p_hi = m_hi;
        p_lo = m_lo;
      end
      sa = $signed(a);
      sb = $signed(b);
      if (m) begin
        prod = sa * sb;
        m_hi = prod[63:32];
        m_lo = prod[31:0];
        m_mult = 1;
        m_dz = 0;
        lat = mult_latency(b);
      end else if (b == '0) begin
        m_hi = a;
        m_lo = '1;
        m_mult = 0;
        m_dz = 1;
        lat = 1;
      end else begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
        m_mult = 0;
        m_dz = 0;
        lat = W + 2;
      end
      m_start = cyc;
      m_done_at = cyc + lat;
      m_active = 1;
    end
    tick();
    mult_start = 0;
    div_start = 0;
  endtask

  always @(negedge clk) begin
    bit in_op, at_done;
    logic [W-1:0] e_hi, e_lo;
    in_op   = m_active && cyc >= m_start + 1 && cyc <= m_done_at;
    at_done = m_active && cyc == m_done_at;
    e_hi = (m_active && cyc >= m_done_at) ? m_hi : p_hi;
    e_lo = (m_active && cyc >= m_done_at) ? m_lo : p_lo;
    chk("busy", busy, in_op);
    chk("mult_done", mult_done, at_done && m_mult);
    chk("div_done", div_done, at_done && !m_mult);
    chk("div_by_zero", div_by_zero, at_done && m_dz);
    chk("hi_out", hi_out, e_hi);
    chk("lo_out", lo_out, e_lo);
  end

  task automatic run_op(input string name, input bit m, input bit d,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input bit exp_dz);
    int s;
    bit seen;
    s = cyc;
    issue(m, d, a, b);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (mult_done || div_done) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk({name, " done seen"}, seen, 1);
    if (seen) begin
      chk({name, " latency"}, cyc - s, exp_lat);
      chk({name, " kind"}, mult_done, m);
      chk({name, " hi"}, hi_out, exp_hi);
      chk({name, " lo"}, lo_out, exp_lo);
      chk({name, " dz"}, div_by_zero, exp_dz);
      tick();
      chk({name, " busy after"}, busy, 0);
    end
  endtask

  int lat_m7, lat_m80, lat_m0, lat_m4;

  initial begin
`ifdef MULT_DIV_EARLY_OUT_EN
    lat_m7 = 5; lat_m80 = 34; lat_m0 = 3; lat_m4 = 6;
`else
    lat_m7 = 34; lat_m80 = 34; lat_m0 = 34; lat_m4 = 34;
`endif
    tick();
    tick();
    chk("reset busy", busy, 0);
    chk("reset hi", hi_out, 0);
    chk("reset lo", lo_out, 0);
    reset = 1;
    tick();

    run_op("mult 7x-3", 1, 0, 32'd7, 32'hFFFF_FFFD, lat_m7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("mult min x min", 1, 0, 32'h8000_0000, 32'h8000_0000, lat_m80, 32'h4000_0000, 32'h0, 0);
    run_op("div -7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 0);
    run_op("div 5/0", 0, 1, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1);
    run_op("mult x0", 1, 0, 32'h1234_5678, 32'd0, lat_m0, 32'h0, 32'h0, 0);
    run_op("div -100/7", 0, 1, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0);

    // Simultaneous starts, ignored start while busy, then reset mid-operation.
    begin
      int s;
      s = cyc;
      issue(1, 1, 32'd6, 32'd7);
      repeat (4) tick();
      chk("cycle-5 position", cyc - s, 5);
      issue(0, 1, 32'd9, 32'd3);
      repeat (4) tick();
      chk("busy before reset", busy, 1);
      reset = 0;
      m_active = 0;
      p_hi = '0;
      p_lo = '0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort mult_done", mult_done, 0);
      chk("abort div_done", div_done, 0);
      chk("abort hi", hi_out, 0);
      chk("abort lo", lo_out, 0);
      tick();
      tick();
      reset = 1;
      tick();
    end

    run_op("mult 3x4", 1, 0, 32'd3, 32'd4, lat_m4, 32'h0, 32'd12, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
